// File: rtl/jk_counter_sequencer.sv
// J/K drive sequencer that turns a bank of JK flip-flops into a loadable, modulo-N,
// up/down counter with burst length. Define JK_SEQ_CHECK_EN to enable the readback checker.
module jk_counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [7:0]       burst_len,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_PAUSE} state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [7:0]       tick_q, tick_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] up_t, dn_t;
  logic [WIDTH-1:0] step_j, step_k;
  logic             step_tc;
  logic             run_up, run_dn;
  logic             final_step;

  // Stage i toggles when every lower stage is 1 (up) or 0 (down).
  always_comb begin
    up_t   = '0;
    dn_t   = '0;
    run_up = 1'b1;
    run_dn = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_t[i] = run_up;
      dn_t[i] = run_dn;
      run_up  = run_up & q[i];
      run_dn  = run_dn & ~q[i];
    end
  end

  always_comb begin
    step_j  = '0;
    step_k  = '0;
    step_tc = 1'b0;
    if (dir) begin
      if (q >= mod_q) begin
        step_k  = '1;
        step_tc = 1'b1;
      end else begin
        step_j = up_t;
        step_k = up_t;
      end
    end else begin
      if ((q == '0) || (q > mod_q)) begin
        step_j  = mod_q;
        step_k  = ~mod_q;
        step_tc = 1'b1;
      end else begin
        step_j = dn_t;
        step_k = dn_t;
      end
    end
  end

  always_comb begin
    j  = '0;
    k  = '0;
    tc = 1'b0;
    case (state_q)
      S_LOAD: begin
        j = load_val;
        k = ~load_val;
      end
      S_RUN: begin
        j  = step_j;
        k  = step_k;
        tc = step_tc;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    mod_d      = mod_q;
    tick_d     = tick_q;
    done_d     = 1'b0;
    final_step = (state_q == S_RUN) && (tick_q == 8'd1);
    if ((state_q == S_RUN) && (tick_q != 8'd0)) tick_d = tick_q - 8'd1;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (load) begin
            state_d = S_LOAD;
            ret_d   = state_q;
          end else if (start) begin
            state_d = S_RUN;
            if (state_q == S_IDLE) begin
              mod_d  = mod_val;
              tick_d = burst_len;
            end
          end
        end
        S_LOAD: state_d = ret_q;
        // A final step completes its burst even if hold arrives alongside it.
        S_RUN: begin
          if (final_step) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (hold) begin
            state_d = S_PAUSE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      mod_q   <= '1;
      tick_q  <= 8'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      mod_q   <= mod_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done = done_q;

`ifdef JK_SEQ_CHECK_EN
  logic [WIDTH-1:0] nxt_val;
  logic [WIDTH-1:0] shadow_q;
  logic             chk_q;
  logic             err_q;

  // Value the bank should hold after the step currently being driven.
  always_comb begin
    nxt_val = q;
    if (dir) begin
      if (q >= mod_q) nxt_val = '0;
      else            nxt_val = q + 1'b1;
    end else begin
      if ((q == '0) || (q > mod_q)) nxt_val = mod_q;
      else                          nxt_val = q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      chk_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chk_q <= (state_q == S_LOAD) || (state_q == S_RUN);
      if (state_q == S_LOAD)     shadow_q <= load_val;
      else if (state_q == S_RUN) shadow_q <= nxt_val;
      if (chk_q && (q != shadow_q)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// Bench for jk_counter_sequencer: behavioural master-slave JK bank plus a
// table of per-cycle stimulus and expected outputs, then reset/checker sequences.
module tb_jk_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, hold, dir, load;
  logic [3:0] load_val, mod_val;
  logic [7:0] burst_len;
  logic [3:0] q, j, k;
  logic       busy, tc, done, err;
  logic [3:0] q_m;
  logic [3:0] stuck;

  int checks = 0;
  int errors = 0;

  jk_counter_sequencer #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .hold(hold), .dir(dir),
    .load(load), .load_val(load_val), .mod_val(mod_val), .burst_len(burst_len),
    .q(q), .j(j), .k(k), .busy(busy), .tc(tc), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Master captures on the rising edge, slave drives q on the falling edge.
  always @(posedge clk or negedge rst)
    if (!rst) q_m <= 4'h0;
    else      q_m <= (j & ~q) | (~k & q);

  always @(negedge clk or negedge rst)
    if (!rst) q <= 4'h0;
    else      q <= q_m & ~stuck;

  typedef struct {
    logic       st, sp, hd, dr, ld;
    logic [3:0] lv, mv;
    logic [7:0] bl;
    logic [3:0] eq, ej, ek;
    logic       eb, et, ed;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic st, sp, hd, dr, ld, input logic [3:0] lv, mv,
                   input logic [7:0] bl, input logic [3:0] eq, ej, ek,
                   input logic eb, et, ed);
    vec_t r;
    r.st = st; r.sp = sp; r.hd = hd; r.dr = dr; r.ld = ld;
    r.lv = lv; r.mv = mv; r.bl = bl;
    r.eq = eq; r.ej = ej; r.ek = ek; r.eb = eb; r.et = et; r.ed = ed;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the settled second half of the next cycle.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //  st sp hd dr ld  lv    mv    bl     q     j     k    busy tc done
    v(0,0,0,1,1, 4'h3,4'h0,8'd0, 4'h0,4'h3,4'hC, 0,0,0); // 1 load 3
    v(0,0,0,1,0, 4'h3,4'h0,8'd0, 4'h3,4'h0,4'h0, 0,0,0);
    v(1,0,0,1,0, 4'h3,4'h5,8'd0, 4'h3,4'h7,4'h7, 1,0,0); // start up, mod 5
    v(0,0,0,1,0, 4'h3,4'h5,8'd0, 4'h4,4'h1,4'h1, 1,0,0);
    v(0,0,0,1,0, 4'h3,4'h5,8'd0, 4'h5,4'h0,4'hF, 1,1,0); // wrap step
    v(0,0,0,1,0, 4'h3,4'h5,8'd0, 4'h0,4'h1,4'h1, 1,0,0);
    v(0,0,0,1,0, 4'h3,4'h5,8'd0, 4'h1,4'h3,4'h3, 1,0,0);
    v(0,1,0,1,0, 4'h3,4'h5,8'd0, 4'h2,4'h0,4'h0, 0,0,0); // 8 stop
    v(0,0,0,1,1, 4'h0,4'h5,8'd0, 4'h2,4'h0,4'hF, 0,0,0); // load 0
    v(0,0,0,1,0, 4'h0,4'h5,8'd0, 4'h0,4'h0,4'h0, 0,0,0);
    v(1,0,0,0,0, 4'h0,4'h9,8'd0, 4'h0,4'h9,4'h6, 1,1,0); // down from 0 wraps to 9
    v(0,0,0,0,0, 4'h0,4'h9,8'd0, 4'h9,4'h1,4'h1, 1,0,0);
    v(0,0,0,0,0, 4'h0,4'h9,8'd0, 4'h8,4'hF,4'hF, 1,0,0);
    v(0,0,0,0,0, 4'h0,4'h9,8'd0, 4'h7,4'h1,4'h1, 1,0,0);
    v(0,1,0,0,0, 4'h0,4'h9,8'd0, 4'h6,4'h0,4'h0, 0,0,0); // 15 stop
    v(0,0,0,1,1, 4'h0,4'h9,8'd0, 4'h6,4'h0,4'hF, 0,0,0); // load 0
    v(0,0,0,1,0, 4'h0,4'h9,8'd0, 4'h0,4'h0,4'h0, 0,0,0);
    v(1,0,0,1,0, 4'h0,4'hF,8'd3, 4'h0,4'h1,4'h1, 1,0,0); // burst of 3
    v(0,0,0,1,0, 4'h0,4'hF,8'd3, 4'h1,4'h3,4'h3, 1,0,0);
    v(0,0,0,1,0, 4'h0,4'hF,8'd3, 4'h2,4'h1,4'h1, 1,0,0);
    v(0,0,0,1,0, 4'h0,4'hF,8'd3, 4'h3,4'h0,4'h0, 0,0,1); // done pulse
    v(0,0,0,1,0, 4'h0,4'hF,8'd3, 4'h3,4'h0,4'h0, 0,0,0);
    v(1,0,0,1,0, 4'h0,4'hF,8'd4, 4'h3,4'h7,4'h7, 1,0,0); // burst of 4 with pause
    v(0,0,1,1,0, 4'h0,4'hF,8'd4, 4'h4,4'h0,4'h0, 1,0,0);
    v(0,0,1,1,0, 4'h0,4'hF,8'd4, 4'h4,4'h0,4'h0, 1,0,0);
    v(1,0,0,1,0, 4'h0,4'hF,8'd9, 4'h4,4'h1,4'h1, 1,0,0); // resume, burst not relatched
    v(0,0,0,1,0, 4'h0,4'hF,8'd9, 4'h5,4'h3,4'h3, 1,0,0);
    v(0,0,0,1,0, 4'h0,4'hF,8'd9, 4'h6,4'h1,4'h1, 1,0,0);
    v(0,0,0,1,0, 4'h0,4'hF,8'd9, 4'h7,4'h0,4'h0, 0,0,1);
    v(0,0,0,1,0, 4'h0,4'hF,8'd9, 4'h7,4'h0,4'h0, 0,0,0);
    v(1,1,0,1,0, 4'h0,4'hF,8'd0, 4'h7,4'h0,4'h0, 0,0,0); // stop beats start
    v(0,0,0,1,0, 4'h0,4'hF,8'd0, 4'h7,4'h0,4'h0, 0,0,0);
    v(1,0,0,1,1, 4'hA,4'hF,8'd0, 4'h7,4'hA,4'h5, 0,0,0); // load beats start
    v(0,0,0,1,0, 4'hA,4'hF,8'd0, 4'hA,4'h0,4'h0, 0,0,0);
    v(0,0,0,1,0, 4'hA,4'hF,8'd0, 4'hA,4'h0,4'h0, 0,0,0);
    v(1,0,0,1,0, 4'hA,4'h0,8'd0, 4'hA,4'h0,4'hF, 1,1,0); // mod 0 pins count at 0
    v(0,0,0,1,0, 4'hA,4'h0,8'd0, 4'h0,4'h0,4'hF, 1,1,0);
    v(0,0,0,0,0, 4'hA,4'h0,8'd0, 4'h0,4'h0,4'hF, 1,1,0);
    v(0,1,0,0,0, 4'hA,4'h0,8'd0, 4'h0,4'h0,4'h0, 0,0,0);
    v(0,0,0,0,1, 4'hC,4'h0,8'd0, 4'h0,4'hC,4'h3, 0,0,0); // load C
    v(0,0,0,0,0, 4'hC,4'h0,8'd0, 4'hC,4'h0,4'h0, 0,0,0);
    v(1,0,0,0,0, 4'hC,4'h9,8'd0, 4'hC,4'h9,4'h6, 1,1,0); // down above mod
    v(0,0,1,0,0, 4'hC,4'h9,8'd0, 4'h9,4'h0,4'h0, 1,0,0);
    v(0,0,0,0,1, 4'h2,4'h9,8'd0, 4'h9,4'h2,4'hD, 0,0,0); // load from PAUSE
    v(0,0,0,0,0, 4'h2,4'h9,8'd0, 4'h2,4'h0,4'h0, 1,0,0);
    v(1,0,0,0,0, 4'h2,4'h9,8'd0, 4'h2,4'h3,4'h3, 1,0,0);
    v(0,1,0,0,0, 4'h2,4'h9,8'd0, 4'h1,4'h0,4'h0, 0,0,0);

    rst = 1'b0; start = 0; stop = 0; hold = 0; dir = 1; load = 0;
    load_val = 4'h0; mod_val = 4'h0; burst_len = 8'd0; stuck = 4'h0;
    cyc();
    cyc();
    chk("reset q", {4'h0, q}, 8'h00);
    chk("reset j", {4'h0, j}, 8'h00);
    chk("reset k", {4'h0, k}, 8'h00);
    chk("reset busy", {7'h0, busy}, 8'h00);
    chk("reset tc", {7'h0, tc}, 8'h00);
    chk("reset done", {7'h0, done}, 8'h00);
    chk("reset err", {7'h0, err}, 8'h00);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; stop = vecs[i].sp; hold = vecs[i].hd; dir = vecs[i].dr;
      load = vecs[i].ld; load_val = vecs[i].lv; mod_val = vecs[i].mv;
      burst_len = vecs[i].bl;
      cyc();
      chk($sformatf("row%0d q", i + 1), {4'h0, q}, {4'h0, vecs[i].eq});
      chk($sformatf("row%0d j", i + 1), {4'h0, j}, {4'h0, vecs[i].ej});
      chk($sformatf("row%0d k", i + 1), {4'h0, k}, {4'h0, vecs[i].ek});
      chk($sformatf("row%0d busy", i + 1), {7'h0, busy}, {7'h0, vecs[i].eb});
      chk($sformatf("row%0d tc", i + 1), {7'h0, tc}, {7'h0, vecs[i].et});
      chk($sformatf("row%0d done", i + 1), {7'h0, done}, {7'h0, vecs[i].ed});
      chk($sformatf("row%0d err", i + 1), {7'h0, err}, 8'h00);
    end

    // Asynchronous reset in the middle of a run.
    start = 1; stop = 0; hold = 0; dir = 1; load = 0; mod_val = 4'hF; burst_len = 8'd0;
    cyc();
    start = 0;
    chk("midrun busy", {7'h0, busy}, 8'h01);
    chk("midrun j", {4'h0, j}, 8'h03);
    rst = 1'b0;
    #1;
    chk("rst async j", {4'h0, j}, 8'h00);
    chk("rst async k", {4'h0, k}, 8'h00);
    chk("rst async busy", {7'h0, busy}, 8'h00);
    chk("rst async tc", {7'h0, tc}, 8'h00);
    chk("rst async q", {4'h0, q}, 8'h00);
    cyc();
    rst = 1'b1;
    cyc();
    chk("post rst busy", {7'h0, busy}, 8'h00);
    chk("post rst q", {4'h0, q}, 8'h00);
    chk("post rst j", {4'h0, j}, 8'h00);

`ifdef JK_SEQ_CHECK_EN
    // q bit 0 stuck low while counting up.
    stuck = 4'h1;
    start = 1; dir = 1; mod_val = 4'hF; burst_len = 8'd0;
    cyc();
    start = 0;
    chk("stuck first step err", {7'h0, err}, 8'h00);
    cyc();
    cyc();
    chk("stuck err set", {7'h0, err}, 8'h01);
    stop = 1;
    stuck = 4'h0;
    cyc();
    stop = 0;
    cyc();
    cyc();
    chk("err sticky", {7'h0, err}, 8'h01);
    rst = 1'b0;
    #1;
    chk("err cleared by rst", {7'h0, err}, 8'h00);
    cyc();
    rst = 1'b1;
    cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
